// File: rtl/sap1_program_loader.sv
// Program-load and run-control sequencer for the SAP-1 core: streams host bytes
// into the program RAM while holding the CPU in reset, then releases it until HLT.
module sap1_program_loader #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int RUN_HOLD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    input  logic              halt,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_reset,
    output logic              running,
    output logic              done,
    output logic [ADDR_W:0]   load_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WRITE   = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4,
        S_HALTED  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] TOP_ADDR  = {ADDR_W{1'b1}};
    localparam logic [3:0]        HOLD_INIT = 4'(RUN_HOLD);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                last_q, last_d;
    logic [ADDR_W:0]     load_count_q, load_count_d;
    logic [3:0]          hold_q, hold_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_cnt_q   <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            last_q       <= 1'b0;
            load_count_q <= '0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            addr_cnt_q   <= addr_cnt_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            last_q       <= last_d;
            load_count_q <= load_count_d;
            hold_q       <= hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_cnt_d   = addr_cnt_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        last_d       = last_q;
        load_count_d = load_count_q;
        hold_d       = hold_q;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    load_count_d = '0;
                    addr_cnt_d   = '0;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                if (byte_valid) begin
                    ram_wdata_d = byte_data;
                    ram_addr_d  = addr_cnt_q;
                    last_d      = byte_last;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                load_count_d = load_count_q + (ADDR_W+1)'(1);
                // The top address always ends the load so the counter never wraps.
                if (last_q || (ram_addr_q == TOP_ADDR)) begin
                    hold_d  = HOLD_INIT;
                    state_d = S_RELEASE;
                end else begin
                    addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                    state_d    = S_LOAD;
                end
            end
            S_RELEASE: begin
                if (hold_q <= 4'd1) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_d = S_HALTED;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs are pure state decodes, so no input reaches an output combinationally.
    always_comb begin
        byte_ready = (state_q == S_LOAD);
        ram_we     = (state_q == S_WRITE);
        running    = (state_q == S_RUN);
        done       = (state_q == S_HALTED);
        cpu_reset  = (state_q == S_IDLE) || (state_q == S_LOAD) ||
                     (state_q == S_WRITE) || (state_q == S_RELEASE);
    end

    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign load_count = load_count_q;

endmodule

// File: doc/sap1_program_loader.md
# sap1_program_loader

Program-load and run-control sequencer for the SAP-1 core. It accepts program bytes from an external valid/ready byte source and writes them into the 16x8 program RAM at consecutive addresses. It holds the CPU in reset while loading, then releases it for a fixed number of cycles and monitors `halt`. It sits between the external host interface and the SAP-1 top level, owning the RAM write port and the CPU reset line.

## Interface
Parameters:
- `ADDR_W`, default 4: RAM address width; the RAM depth is 2**ADDR_W.
- `DATA_W`, default 8: RAM word width.
- `RUN_HOLD`, default 2: cycles `cpu_reset` stays high after the final write before release; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- `start`  in  1  sampled level; begins a load from address 0 when in IDLE or HALTED.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  DATA_W  program byte.
- `byte_last`  in  1  qualifies `byte_data`: this byte is the final one.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `halt`  in  1  HLT indication from the SAP-1 controller.
- `ram_we`  out  1  one-cycle RAM write strobe.
- `ram_addr`  out  ADDR_W  write address.
- `ram_wdata`  out  DATA_W  write data.
- `cpu_reset`  out  1  drives the SAP-1 `reset`; high holds the CPU cleared.
- `running`  out  1  CPU released and not halted.
- `done`  out  1  CPU has halted since the last load.
- `load_count`  out  ADDR_W+1  number of bytes written in the current or last load.

## Operation
- States: IDLE, LOAD, WRITE, RELEASE, RUN, HALTED.
- IDLE: `cpu_reset`=1 and `byte_ready`=0. When `start`=1: `load_count`←0, address counter←0, go to LOAD.
- LOAD: `byte_ready`=1. Accept on `byte_valid`&`byte_ready`: capture `byte_data` into `ram_wdata`, address counter into `ram_addr`, and `byte_last` into a flag. Go to WRITE.
- WRITE: `ram_we`=1 for exactly this cycle; `byte_ready`=0; `load_count` increments.
  - If the captured last flag is set, or `ram_addr`=2**ADDR_W−1, go to RELEASE with the hold counter←RUN_HOLD.
  - Otherwise increment the address counter and return to LOAD.
- RELEASE: `cpu_reset`=1. The hold counter decrements each cycle; when it reaches 1, go to RUN.
- RUN: `cpu_reset`=0 and `running`=1. When `halt`=1, go to HALTED. `start` is ignored in RUN.
- HALTED: `cpu_reset`=0, `running`=0, `done`=1. The CPU output register keeps its value. When `start`=1, assert `cpu_reset`, clear `done`, and go to LOAD as from IDLE.
- Addresses never wrap. A byte accepted at the top address ends the load even if `byte_last`=0; `byte_ready` is never asserted after it.
- RAM locations not written in a short load keep their previous contents.
- `byte_valid` is ignored outside LOAD. `byte_data` and `byte_last` are don't-care when `byte_valid`=0.
- Reset asserted mid-load or mid-run: return immediately to IDLE. Any partial RAM contents remain; no write strobe is issued during or after reset.

## Timing
- Reset values: state IDLE, `byte_ready` 0, `ram_we` 0, `ram_addr` 0, `ram_wdata` 0, `cpu_reset` 1, `running` 0, `done` 0, `load_count` 0.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- `start` to first `byte_ready`: 1 cycle.
- Accept edge to `ram_we` high: 1 cycle. `ram_addr` and `ram_wdata` are stable during `ram_we`.
- Maximum throughput: one byte per 2 cycles.
- Final `ram_we` to `cpu_reset` low: RUN_HOLD+1 cycles.
- `halt` high to `running` low and `done` high: 1 cycle.
- `start` and `halt` high together in RUN: `halt` wins.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → all outputs at reset values before the next edge; `cpu_reset`=1.
- Full load: `start`, then 16 bytes 0x00..0x0F with `byte_valid` held high → 16 `ram_we` pulses at addresses 0..15, `ram_wdata` equal to the address, `load_count`=16. `cpu_reset` falls 3 cycles after the last `ram_we` (RUN_HOLD=2); `running`=1.
- Short load: bytes 0x1E, 0x2F, 0xF0 with `byte_last` on the third → 3 writes, `load_count`=3, then RELEASE→RUN. `byte_ready` never rises again.
- Backpressure: `byte_valid` toggled at random with gaps → no write is issued without a prior accept; addresses stay consecutive; no byte is lost or duplicated.
- Halt and reload: in RUN, pulse `halt` → `done`=1, `running`=0. Then `start` → `cpu_reset`=1, `done`=0, and the next write goes to address 0.
- Reset mid-load: assert `reset` after 5 writes → IDLE, no further `ram_we`. A subsequent `start` begins again at address 0 with `load_count`=0.
